// File: rtl/chip8_call_stack.sv
// chip8_call_stack: parametrised return-address stack
// for the Chip-8 CPU with peek, occupancy and sticky errors.
module chip8_call_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic [1:0]       WE,
  input  logic [WIDTH-1:0] writedata,
  input  logic             clr_err,
  output logic [WIDTH-1:0] outdata,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_rep;
  logic          ovf_ev;
  logic          unf_ev;

  // Decode the requested operation against the current occupancy;
  // illegal operations are suppressed and turned into error events.
  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    wr_idx  = AW'(count);
    top_idx = AW'(count - 1'b1);
    do_push = (WE == 2'b01) && !full;
    do_pop  = (WE == 2'b10) && !empty;
    do_rep  = (WE == 2'b11) && !empty;
    ovf_ev  = (WE == 2'b01) && full;
    unf_ev  = WE[1] && empty;
    top     = empty ? '0 : mem[top_idx];
  end

  // Storage array; not reset, only valid entries are ever observed.
  always_ff @(posedge cpu_clk) begin
    if (!reset) begin
      if (do_push) mem[wr_idx] <= writedata;
      if (do_rep)  mem[top_idx] <= writedata;
    end
  end

  // Occupancy, popped value and sticky error flags.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      count     <= '0;
      outdata   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) count <= count + 1'b1;
      if (do_pop)  count <= count - 1'b1;
      if (do_pop || do_rep) outdata <= mem[top_idx];
      overflow  <= ovf_ev | (overflow & ~clr_err);
      underflow <= unf_ev | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_chip8_call_stack.sv
// tb_chip8_call_stack: directed vectors with a queued
// scoreboard checked by an independent monitor.
module tb_chip8_call_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             cpu_clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       WE = 2'b00;
  logic [WIDTH-1:0] writedata = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] outdata;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  typedef struct {
    string       name;
    int unsigned cnt;
    logic [15:0] tp;
    logic [15:0] od;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  chip8_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk),
    .reset(reset),
    .WE(WE),
    .writedata(writedata),
    .clr_err(clr_err),
    .outdata(outdata),
    .top(top),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string n, input string f,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  // Monitor: outputs are stable by the falling edge.
  always @(negedge cpu_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "count", 16'(count), 16'(e.cnt));
      chk(e.name, "top", top, e.tp);
      chk(e.name, "outdata", outdata, e.od);
      chk(e.name, "empty", 16'(empty), 16'(e.cnt == 0));
      chk(e.name, "full", 16'(full), 16'(e.cnt == DEPTH));
      chk(e.name, "overflow", 16'(overflow), 16'(e.ovf));
      chk(e.name, "underflow", 16'(underflow), 16'(e.unf));
    end
  end

  task automatic step(input string n, input logic rst,
                      input logic [1:0] we,
                      input logic [15:0] wd,
                      input logic clr,
                      input int unsigned ec,
                      input logic [15:0] et,
                      input logic [15:0] eo,
                      input logic eov, input logic eun);
    exp_t e;
    @(negedge cpu_clk);
    reset = rst;
    WE = we;
    writedata = wd;
    clr_err = clr;
    @(posedge cpu_clk);
    e.name = n;
    e.cnt = ec;
    e.tp = et;
    e.od = eo;
    e.ovf = eov;
    e.unf = eun;
    q.push_back(e);
  endtask

  initial begin
    step("rst",    1, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("idle",   0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("push1",  0, 2'b01, 16'hF000, 0, 1, 16'hF000, 16'h0000, 0, 0);
    step("push2",  0, 2'b01, 16'h0F00, 0, 2, 16'h0F00, 16'h0000, 0, 0);
    step("push3",  0, 2'b01, 16'h00F0, 0, 3, 16'h00F0, 16'h0000, 0, 0);
    step("push4",  0, 2'b01, 16'h000F, 0, 4, 16'h000F, 16'h0000, 0, 0);
    step("pop1",   0, 2'b10, 16'h0000, 0, 3, 16'h00F0, 16'h000F, 0, 0);
    step("pop2",   0, 2'b10, 16'h0000, 0, 2, 16'h0F00, 16'h00F0, 0, 0);
    step("pop3",   0, 2'b10, 16'h0000, 0, 1, 16'hF000, 16'h0F00, 0, 0);
    step("pop4",   0, 2'b10, 16'h0000, 0, 0, 16'h0000, 16'hF000, 0, 0);
    step("fill1",  0, 2'b01, 16'hF000, 0, 1, 16'hF000, 16'hF000, 0, 0);
    step("fill2",  0, 2'b01, 16'h0F00, 0, 2, 16'h0F00, 16'hF000, 0, 0);
    step("fill3",  0, 2'b01, 16'h00F0, 0, 3, 16'h00F0, 16'hF000, 0, 0);
    step("fill4",  0, 2'b01, 16'h000F, 0, 4, 16'h000F, 16'hF000, 0, 0);
    step("ovpush", 0, 2'b01, 16'h1234, 0, 4, 16'h000F, 16'hF000, 1, 0);
    step("ovpop",  0, 2'b10, 16'h0000, 0, 3, 16'h00F0, 16'h000F, 1, 0);
    step("push88", 0, 2'b01, 16'h8888, 0, 4, 16'h8888, 16'h000F, 1, 0);
    step("pop88",  0, 2'b10, 16'h0000, 0, 3, 16'h00F0, 16'h8888, 1, 0);
    step("clrovf", 0, 2'b00, 16'h0000, 1, 3, 16'h00F0, 16'h8888, 0, 0);
    step("drain1", 0, 2'b10, 16'h0000, 0, 2, 16'h0F00, 16'h00F0, 0, 0);
    step("drain2", 0, 2'b10, 16'h0000, 0, 1, 16'hF000, 16'h0F00, 0, 0);
    step("drain3", 0, 2'b10, 16'h0000, 0, 0, 16'h0000, 16'hF000, 0, 0);
    step("pushA",  0, 2'b01, 16'h0A00, 0, 1, 16'h0A00, 16'hF000, 0, 0);
    step("repB",   0, 2'b11, 16'h0B00, 0, 1, 16'h0B00, 16'h0A00, 0, 0);
    step("popB",   0, 2'b10, 16'h0000, 0, 0, 16'h0000, 16'h0B00, 0, 0);
    step("repE",   0, 2'b11, 16'h1111, 0, 0, 16'h0000, 16'h0B00, 0, 1);
    step("popEc",  0, 2'b10, 16'h0000, 1, 0, 16'h0000, 16'h0B00, 0, 1);
    step("clrunf", 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'h0B00, 0, 0);
    step("p1",     0, 2'b01, 16'h0001, 0, 1, 16'h0001, 16'h0B00, 0, 0);
    step("p2",     0, 2'b01, 16'h0002, 0, 2, 16'h0002, 16'h0B00, 0, 0);
    step("p3",     0, 2'b01, 16'h0003, 0, 3, 16'h0003, 16'h0B00, 0, 0);
    step("rstop",  1, 2'b01, 16'h9999, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("push55", 0, 2'b01, 16'h0055, 0, 1, 16'h0055, 16'h0000, 0, 0);
    step("idle2",  0, 2'b00, 16'h0000, 0, 1, 16'h0055, 16'h0000, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge cpu_clk);
    @(posedge cpu_clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
